ps2_rx: RTL and testbench
=========================

Name: ps2_rx

Overview:
- Receiving end of the emulated PS/2 link. It sits inside a core and consumes the ps2_kbd_clk/ps2_kbd_data (or mouse) pair driven by the IO controller block.
- Deframes 11-bit PS/2 frames into bytes in the clk_sys domain, checks parity and stop bit, and aborts stalled frames.
- Tracks keyboard E0/F0 prefixes and emits decoded key events for the core's keyboard matrix logic.

Parameters:
- FILTER, 8, number of consecutive clk_sys cycles a synchronised line must differ from its filtered level before the filtered level changes (valid range 1..255).
- TIMEOUT, 4096, clk_sys cycles with no filtered ps2_clk falling edge, while a frame is in progress, before the frame is aborted (valid range 16..65535).

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- ps2_clk  in  1  PS/2 clock line; asynchronous to clk_sys; idle high.
- ps2_data  in  1  PS/2 data line; asynchronous; idle high.
- rx_byte  out  8  last correctly received byte.
- rx_strobe  out  1  one-cycle pulse; rx_byte is valid in the same cycle.
- rx_err  out  1  one-cycle pulse on parity error, stop-bit error or timeout.
- busy  out  1  high while a frame is in progress (FSM not IDLE).
- key_code  out  8  scan code of the last key event.
- key_ext  out  1  key event was E0-prefixed.
- key_pressed  out  1  1 = make, 0 = break (F0-prefixed).
- key_strobe  out  1  one-cycle pulse; key_* outputs are valid in the same cycle.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge):
  - All outputs go to 0.
  - Synchronisers and filtered levels go to 1.
  - FSM goes to IDLE; bit count, timeout counter and prefix flags are cleared.
  - Reset mid-frame discards the partial frame and produces no rx_err.
- Input conditioning:
  - Each line passes through a 2-FF synchroniser, then the filter.
  - Filter counter: cleared whenever the synchronised value equals the filtered value. Otherwise it increments; when it reaches FILTER, the filtered value takes the synchronised value and the counter clears.
  - Sample event = filtered clk at 1 in the previous cycle and 0 in the current cycle. Data is the filtered data in that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on sample events, except timeout.
  - IDLE: data=0 -> DATA with bit count 0. Data=1 -> stay in IDLE (spurious edge ignored; no error).
  - DATA: shift register shifts right with the new bit entering [7] (LSB first). After the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: the frame is good when stop=1 and the XOR of the 8 data bits and the parity bit equals 1 (odd parity).
    - Good frame: rx_byte <= shifted byte, rx_strobe=1 in the next cycle.
    - Otherwise: rx_err=1 in the next cycle and rx_byte is unchanged.
    - Both cases return to IDLE.
- Timeout:
  - The counter clears on every sample event and while in IDLE; it increments otherwise, saturating.
  - Reaching TIMEOUT outside IDLE -> IDLE and rx_err pulse in the next cycle.
- Latency: rx_strobe rises 1 cycle after the cycle in which the stop-bit falling edge is detected. From a raw pin edge this is 2 (sync) + FILTER + 1 cycles.
- Prefix decoder: evaluated in the cycle rx_strobe is high, using the received byte.
  - 0xE0 sets ext_pend. 0xF0 sets rel_pend.
  - 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF are raw only: no key event, and prefixes are unchanged.
  - Any other byte: key_strobe=1 in the same cycle as rx_strobe, with key_code=byte, key_ext=ext_pend, key_pressed=~rel_pend. Both prefix flags clear.
  - key_code, key_ext and key_pressed hold their values until the next key event.
  - An rx_err pulse clears both prefix flags.
- Strobes never overlap: rx_strobe and rx_err are mutually exclusive.
- Minimum spacing between strobes is one full frame.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state encoding: IDLE=0, DATA=1, PARITY=2, STOP=3.
  - Prefix constants: PS2_EXT=8'hE0, PS2_REL=8'hF0.
  - Non-key code constants: 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF.
- One sub-module, ps2_line_filter (synchroniser plus glitch filter, FILTER parameter), instantiated twice (clk and data).
- Prefix decoding stays in ps2_rx.

Test Plan:
- Frame 0x1C, parity 0, stop 1, bit period 200 cycles -> rx_byte=0x1C, rx_strobe exactly 1 cycle, key_strobe with key_code=0x1C, key_ext=0, key_pressed=1.
- Frames E0, F0, 75 -> three rx_strobes; exactly one key_strobe with key_code=0x75, key_ext=1, key_pressed=0; then frame 0x75 gives key_ext=0, key_pressed=1.
- Error frames:
  - 0x1C with parity bit 1 -> rx_err pulse, no rx_strobe or key_strobe, rx_byte unchanged.
  - 0x1C with stop bit 0 -> rx_err pulse.
- Glitch and timeout:
  - 5-cycle low glitch on ps2_clk in IDLE (FILTER=8) -> no state change.
  - Start bit plus 4 data bits, then idle 5000 cycles -> rx_err at TIMEOUT, busy=0.
  - Next full 0x29 frame is received correctly.
- F0 then reset_n low mid-way through the next frame -> outputs 0, no rx_err; after release, frame 0x1C gives key_pressed=1.
- Frame 0xFA after E0 -> rx_strobe with rx_byte=0xFA, no key_strobe; following 0x6B gives key_ext=1.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_pkg : shared FSM encoding and scan-code constants for ps2_rx   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_e;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_REL = 8'hF0;

   localparam logic [7:0] PS2_BAT_OK = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERR0   = 8'h00;
   localparam logic [7:0] PS2_ERR1   = 8'hFF;

   // Controller replies that must never reach the key matrix.
   function automatic logic is_raw_code(input logic [7:0] code);
      return (code == PS2_BAT_OK) || (code == PS2_ACK)    ||
             (code == PS2_ECHO)   || (code == PS2_RESEND) ||
             (code == PS2_ERR0)   || (code == PS2_ERR1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_rx_if : PS/2 line inputs plus received byte / key event bus    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ps2_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] rx_byte;
   logic       rx_strobe;
   logic       rx_err;
   logic       busy;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_pressed;
   logic       key_strobe;

   modport master (
      output ps2_clk, ps2_data,
      input  rx_byte, rx_strobe, rx_err, busy,
      input  key_code, key_ext, key_pressed, key_strobe
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output rx_byte, rx_strobe, rx_err, busy,
      output key_code, key_ext, key_pressed, key_strobe
   );
endinterface
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_line_filter : 2-FF synchroniser followed by a persistence      |
// | glitch filter; idles high. rev 1.0                                 |
// +--------------------------------------------------------------------+
module ps2_line_filter #(
   parameter int FILTER = 8
) (
   input  wire logic clk_sys,
   input  wire logic reset_n,
   input  wire logic din,
   output logic      dout
);

   localparam logic [7:0] FILT_LAST = 8'(FILTER);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       filt_q,  filt_d;
   logic [7:0] cnt_q,   cnt_d;

   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      filt_d  = filt_q;
      cnt_d   = 8'd0;
      if (sync2_q != filt_q) begin
         if (cnt_q + 8'd1 == FILT_LAST) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         cnt_q   <= 8'd0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = filt_q;

endmodule
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_rx : PS/2 frame receiver with E0/F0 prefix key-event decoder   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 4096
) (
   input  wire logic clk_sys,
   input  wire logic reset_n,
   ps2_rx_if.slave   bus
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   logic clk_f;
   logic data_f;

   ps2_line_filter #(.FILTER(FILTER)) u_clk_filt (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .din     (bus.ps2_clk),
      .dout    (clk_f)
   );

   ps2_line_filter #(.FILTER(FILTER)) u_data_filt (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .din     (bus.ps2_data),
      .dout    (data_f)
   );

   state_e      state_q,       state_d;
   logic        clk_prev_q,    clk_prev_d;
   logic [2:0]  bit_cnt_q,     bit_cnt_d;
   logic [7:0]  shift_q,       shift_d;
   logic        parity_q,      parity_d;
   logic [15:0] to_cnt_q,      to_cnt_d;
   logic [7:0]  rx_byte_q,     rx_byte_d;
   logic        rx_strobe_q,   rx_strobe_d;
   logic        rx_err_q,      rx_err_d;
   logic        busy_q,        busy_d;
   logic [7:0]  key_code_q,    key_code_d;
   logic        key_ext_q,     key_ext_d;
   logic        key_pressed_q, key_pressed_d;
   logic        key_strobe_q,  key_strobe_d;
   logic        ext_pend_q,    ext_pend_d;
   logic        rel_pend_q,    rel_pend_d;

   logic sample;
   logic frame_ok;

   assign sample   = clk_prev_q & ~clk_f;
   assign frame_ok = data_f & (^{shift_q, parity_q});

   always_comb begin
      state_d       = state_q;
      clk_prev_d    = clk_f;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      parity_d      = parity_q;
      to_cnt_d      = to_cnt_q;
      rx_byte_d     = rx_byte_q;
      rx_strobe_d   = 1'b0;
      rx_err_d      = 1'b0;
      key_code_d    = key_code_q;
      key_ext_d     = key_ext_q;
      key_pressed_d = key_pressed_q;
      key_strobe_d  = 1'b0;
      ext_pend_d    = ext_pend_q;
      rel_pend_d    = rel_pend_q;

      // Stall watchdog: only runs between falling edges of an open frame.
      if (state_q == ST_IDLE || sample) begin
         to_cnt_d = 16'd0;
      end else if (to_cnt_q >= TO_LAST) begin
         to_cnt_d   = 16'd0;
         state_d    = ST_IDLE;
         rx_err_d   = 1'b1;
         ext_pend_d = 1'b0;
         rel_pend_d = 1'b0;
      end else begin
         to_cnt_d = to_cnt_q + 16'd1;
      end

      if (sample) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!data_f) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            ST_DATA: begin
               shift_d   = {data_f, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               parity_d = data_f;
               state_d  = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (frame_ok) begin
                  rx_byte_d   = shift_q;
                  rx_strobe_d = 1'b1;
                  // Decode from shift_q so key_strobe lines up with rx_strobe.
                  if (shift_q == PS2_EXT) begin
                     ext_pend_d = 1'b1;
                  end else if (shift_q == PS2_REL) begin
                     rel_pend_d = 1'b1;
                  end else if (!is_raw_code(shift_q)) begin
                     key_strobe_d  = 1'b1;
                     key_code_d    = shift_q;
                     key_ext_d     = ext_pend_q;
                     key_pressed_d = ~rel_pend_q;
                     ext_pend_d    = 1'b0;
                     rel_pend_d    = 1'b0;
                  end
               end else begin
                  rx_err_d   = 1'b1;
                  ext_pend_d = 1'b0;
                  rel_pend_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         clk_prev_q    <= 1'b1;
         bit_cnt_q     <= 3'd0;
         shift_q       <= 8'd0;
         parity_q      <= 1'b0;
         to_cnt_q      <= 16'd0;
         rx_byte_q     <= 8'd0;
         rx_strobe_q   <= 1'b0;
         rx_err_q      <= 1'b0;
         busy_q        <= 1'b0;
         key_code_q    <= 8'd0;
         key_ext_q     <= 1'b0;
         key_pressed_q <= 1'b0;
         key_strobe_q  <= 1'b0;
         ext_pend_q    <= 1'b0;
         rel_pend_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         clk_prev_q    <= clk_prev_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         parity_q      <= parity_d;
         to_cnt_q      <= to_cnt_d;
         rx_byte_q     <= rx_byte_d;
         rx_strobe_q   <= rx_strobe_d;
         rx_err_q      <= rx_err_d;
         busy_q        <= busy_d;
         key_code_q    <= key_code_d;
         key_ext_q     <= key_ext_d;
         key_pressed_q <= key_pressed_d;
         key_strobe_q  <= key_strobe_d;
         ext_pend_q    <= ext_pend_d;
         rel_pend_q    <= rel_pend_d;
      end
   end

   assign bus.rx_byte     = rx_byte_q;
   assign bus.rx_strobe   = rx_strobe_q;
   assign bus.rx_err      = rx_err_q;
   assign bus.busy        = busy_q;
   assign bus.key_code    = key_code_q;
   assign bus.key_ext     = key_ext_q;
   assign bus.key_pressed = key_pressed_q;
   assign bus.key_strobe  = key_strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ps2_rx : directed PS/2 frames with queue-based output checking  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ps2_rx;

   typedef struct {
      bit         is_err;
      logic [7:0] rxb;
      bit         key;
      logic [7:0] code;
      bit         ext;
      bit         pressed;
   } exp_t;

   logic clk_sys;
   logic reset_n;
   int   tests;
   int   fails;
   exp_t exp_q[$];

   ps2_rx_if bus ();

   ps2_rx #(.FILTER(8), .TIMEOUT(4096)) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   // Bit period 200 cycles: data set while clk high, clk low for the middle 100.
   task automatic send_bits(input logic [10:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = bits[i];
         cyc(50);
         bus.ps2_clk = 1'b0;
         cyc(100);
         bus.ps2_clk = 1'b1;
         cyc(50);
      end
      bus.ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      send_bits({stop, par, b, 1'b0}, 11);
      cyc(100);
   endtask

   task automatic exp_rx(input logic [7:0] b, input bit key, input logic [7:0] code,
                         input bit ext, input bit pressed);
      exp_q.push_back('{is_err: 1'b0, rxb: b, key: key, code: code, ext: ext, pressed: pressed});
   endtask

   task automatic exp_err(input logic [7:0] b, input logic [7:0] code,
                          input bit ext, input bit pressed);
      exp_q.push_back('{is_err: 1'b1, rxb: b, key: 1'b0, code: code, ext: ext, pressed: pressed});
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   // Monitor: every strobe cycle must match the oldest queued expectation.
   always @(negedge clk_sys) begin
      if (reset_n && (bus.rx_strobe || bus.rx_err || bus.key_strobe)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {bus.rx_strobe, bus.rx_err, bus.key_strobe}, 3'b000);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("strobe_kind", {bus.rx_strobe, bus.rx_err}, {!e.is_err, e.is_err});
            check("rx_byte", bus.rx_byte, e.rxb);
            check("key_strobe", bus.key_strobe, e.key);
            check("key_code", bus.key_code, e.code);
            check("key_ext", bus.key_ext, e.ext);
            check("key_pressed", bus.key_pressed, e.pressed);
         end
      end
   end

   initial begin
      tests = 0;
      fails = 0;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      reset_n      = 1'b0;
      cyc(4);
      check("reset_outputs",
            {bus.rx_byte, bus.rx_strobe, bus.rx_err, bus.busy,
             bus.key_code, bus.key_ext, bus.key_pressed, bus.key_strobe}, 32'd0);
      reset_n = 1'b1;
      cyc(10);

      // Plain make code.
      exp_rx(8'h1C, 1, 8'h1C, 0, 1);
      send_frame(8'h1C, 1'b0, 1'b1);
      wait_drain(500);

      // Extended break: E0 F0 75, then plain 75.
      exp_rx(8'hE0, 0, 8'h1C, 0, 1);
      send_frame(8'hE0, 1'b0, 1'b1);
      exp_rx(8'hF0, 0, 8'h1C, 0, 1);
      send_frame(8'hF0, 1'b1, 1'b1);
      exp_rx(8'h75, 1, 8'h75, 1, 0);
      send_frame(8'h75, 1'b0, 1'b1);
      exp_rx(8'h75, 1, 8'h75, 0, 1);
      send_frame(8'h75, 1'b0, 1'b1);
      wait_drain(500);

      // Parity error, then stop-bit error; rx_byte stays 0x75.
      exp_err(8'h75, 8'h75, 0, 1);
      send_frame(8'h1C, 1'b1, 1'b1);
      exp_err(8'h75, 8'h75, 0, 1);
      send_frame(8'h1C, 1'b0, 1'b0);
      wait_drain(500);

      // Error after E0 drops the pending prefix.
      exp_rx(8'hE0, 0, 8'h75, 0, 1);
      send_frame(8'hE0, 1'b0, 1'b1);
      exp_err(8'hE0, 8'h75, 0, 1);
      send_frame(8'h1C, 1'b1, 1'b1);
      exp_rx(8'h1C, 1, 8'h1C, 0, 1);
      send_frame(8'h1C, 1'b0, 1'b1);
      wait_drain(500);

      // Short glitch on clk while idle is filtered out.
      bus.ps2_data = 1'b0;
      bus.ps2_clk  = 1'b0;
      cyc(5);
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      cyc(50);
      check("glitch_busy", bus.busy, 1'b0);
      cyc(200);

      // Stalled frame: start + 4 bits of 0x29, then silence.
      send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
      check("stall_busy_mid", bus.busy, 1'b1);
      exp_err(8'h1C, 8'h1C, 0, 1);
      cyc(5000);
      check("timeout_busy", bus.busy, 1'b0);
      wait_drain(500);
      exp_rx(8'h29, 1, 8'h29, 0, 1);
      send_frame(8'h29, 1'b0, 1'b1);
      wait_drain(500);

      // F0, then reset in the middle of the next frame.
      exp_rx(8'hF0, 0, 8'h29, 0, 1);
      send_frame(8'hF0, 1'b1, 1'b1);
      wait_drain(500);
      send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4);
      reset_n = 1'b0;
      cyc(3);
      check("midframe_reset_outputs",
            {bus.rx_byte, bus.rx_strobe, bus.rx_err, bus.busy,
             bus.key_code, bus.key_ext, bus.key_pressed, bus.key_strobe}, 32'd0);
      reset_n = 1'b1;
      cyc(300);
      check("post_reset_busy", bus.busy, 1'b0);
      exp_rx(8'h1C, 1, 8'h1C, 0, 1);
      send_frame(8'h1C, 1'b0, 1'b1);
      wait_drain(500);

      // Raw ACK between E0 and a key keeps the E0 prefix.
      exp_rx(8'hE0, 0, 8'h1C, 0, 1);
      send_frame(8'hE0, 1'b0, 1'b1);
      exp_rx(8'hFA, 0, 8'h1C, 0, 1);
      send_frame(8'hFA, 1'b1, 1'b1);
      exp_rx(8'h6B, 1, 8'h6B, 1, 1);
      send_frame(8'h6B, 1'b0, 1'b1);
      wait_drain(500);

      cyc(200);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
